uart_port: RTL
==============

# uart_port

Byte-wide 8N1 UART peripheral that sits on the far side of the J1 I/O bus UART strobes. It accepts single-cycle write and read strobes from the CPU I/O decode, then serialises transmit bytes onto `uart_txd`. It deserialises `uart_rxd` into a receive holding register or FIFO, and presents busy/valid/data status for the CPU to poll.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per serial bit. Legal values are 4 or more.
- `clk` in 1: system clock; all logic is clocked on its rising edge.
- `resetq` in 1: asynchronous, active-low reset.
- `uart0_wr` in 1: one-cycle transmit strobe; the byte is on `uart_w`.
- `uart0_rd` in 1: one-cycle receive pop strobe.
- `uart_w` in 8: transmit byte, sampled when `uart0_wr` is high.
- `uart0_busy` out 1: transmitter occupied.
- `uart0_valid` out 1: at least one received byte is pending.
- `uart0_data` out 8: oldest pending received byte; combinational from storage.
- `uart_txd` out 1: serial output; idles high.
- `uart_rxd` in 1: asynchronous serial input.

## Operation
- Reset values: `uart_txd`=1, `uart0_busy`=0, `uart0_valid`=0, `uart0_data`=0x00. The RX synchroniser resets to 1, and both FSMs reset to IDLE.
- Frame format: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly `CLKS_PER_BIT` cycles.
- TX FSM states: IDLE, START, DATA (3-bit index), STOP.
  - IDLE→START when `uart0_wr` is high and busy is low. On that transition the FSM latches `uart_w` and loads the bit counter.
  - START→DATA after one bit period.
  - DATA advances through bit indices 0..7, one bit period each, then →STOP.
  - STOP→IDLE after one bit period.
  - A `uart0_wr` while busy is ignored; the byte is lost and the transfer in progress is unaffected.
- RX path: `uart_rxd` passes through a 2-flop synchroniser. All RX logic uses only the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on synchronised rxd = 0, and the bit counter loads `CLKS_PER_BIT/2`.
  - At mid-start: if rxd is 0, go →DATA; if rxd is 1, it is a false start, go →IDLE.
  - In DATA, sample each bit at its centre, one bit period apart, and shift it in LSB first.
  - At the stop-bit centre: if rxd is 1, commit the byte; if rxd is 0, it is a framing error, discard the byte. Either way go →IDLE on that cycle.
- Pop: `uart0_rd` while valid removes the oldest byte. `uart0_rd` while not valid is ignored.
- `uart0_data` must be stable during the cycle `uart0_rd` is high, so the CPU captures it in that same cycle.

## Timing
- TX: `uart0_busy` is high from the cycle after the accepting `uart0_wr` edge. It stays high for exactly 10×`CLKS_PER_BIT` cycles.
- TX: `uart_txd` falls in the same cycle that busy rises. Busy falls after the full stop bit, so back-to-back writes yield contiguous frames.
- RX latency: `uart0_valid` rises on the cycle after the stop-bit centre sample.
- Simultaneous commit and `uart0_rd`: the pop applies to the old head and the new byte is stored. In non-FIFO mode `uart0_valid` stays 1 and `uart0_data` shows the new byte.
- Overrun in non-FIFO mode: a new commit while valid overwrites the holding register.
- Reset asserted mid-frame: both FSMs abort immediately, `uart_txd` is forced to 1, and any pending byte is discarded.

## Configuration
- `UART_RX_FIFO_EN` defined: RX storage is a 4-entry FIFO.
  - `uart0_valid` means the FIFO is not empty; `uart0_data` is the FIFO head.
  - A commit while the FIFO is full drops the incoming byte; stored bytes are untouched.
  - A simultaneous commit and pop while full succeeds, and the count stays at 4.
- Not defined: RX storage is a single holding register with the overwrite-on-overrun behaviour above.

## Test plan
- TX: with `CLKS_PER_BIT`=8, strobe `uart0_wr` with 0x55 → `uart_txd` shows 0,1,0,1,0,1,0,1,0,1, each bit 8 cycles long; busy is high for exactly 80 cycles. A second `uart0_wr` at cycle 40 → that byte is ignored.
- RX: drive frame 0xA3 on `uart_rxd` → `uart0_valid`=1 and `uart0_data`=0xA3 after the stop-bit centre. Pulse `uart0_rd` → valid=0 on the next cycle.
- False start and framing: a low glitch of 2 cycles (less than a half bit) → no byte. A frame 0x3C with stop bit 0 → valid stays 0.
- Overrun: receive 0x11 then 0x22 with no reads. Without the FIFO → data=0x22. With `UART_RX_FIFO_EN`, receive 5 bytes 0x01..0x05 → four pops return 0x01..0x04, then valid=0.
- Loopback: tie `uart_txd` to `uart_rxd` and send 0x00, 0xFF, 0x80 back-to-back → the same three bytes are received in order.
- Reset mid-frame: assert `resetq`=0 during TX data bit 3 → `uart_txd`=1 and busy=0 immediately. After release, a fresh `uart0_wr` of 0x5A transmits correctly.

Source files
------------

// File: rtl/uart_port.sv
// 8N1 UART peripheral for the J1 I/O bus: strobed TX serialiser plus an RX deserialiser.
// Define UART_RX_FIFO_EN to replace the single RX holding register with a 4-entry FIFO.
module uart_port #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       resetq,
   input  logic       uart0_wr,
   input  logic       uart0_rd,
   input  logic [7:0] uart_w,
   output logic       uart0_busy,
   output logic       uart0_valid,
   output logic [7:0] uart0_data,
   output logic       uart_txd,
   input  logic       uart_rxd
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   tx_state_e        tx_state_q;
   logic [CNT_W-1:0] tx_cnt_q;
   logic [2:0]       tx_idx_q;
   logic [7:0]       tx_shift_q;
   logic             tx_line_q;
   logic             tx_busy_q;

   // Transmit FSM; the line level is registered so it changes exactly on bit boundaries.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (uart0_wr) begin
                  tx_state_q <= TX_START;
                  tx_shift_q <= uart_w;
                  tx_cnt_q   <= BIT_LAST;
                  tx_line_q  <= 1'b0;
                  tx_busy_q  <= 1'b1;
               end
            end
            TX_START: begin
               if (tx_cnt_q == '0) begin
                  tx_state_q <= TX_DATA;
                  tx_cnt_q   <= BIT_LAST;
                  tx_idx_q   <= '0;
                  tx_line_q  <= tx_shift_q[0];
               end else begin
                  tx_cnt_q <= tx_cnt_q - CNT_ONE;
               end
            end
            TX_DATA: begin
               if (tx_cnt_q == '0) begin
                  tx_cnt_q   <= BIT_LAST;
                  tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                  if (tx_idx_q == 3'd7) begin
                     tx_state_q <= TX_STOP;
                     tx_line_q  <= 1'b1;
                  end else begin
                     tx_idx_q  <= tx_idx_q + 3'd1;
                     tx_line_q <= tx_shift_q[1];
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q - CNT_ONE;
               end
            end
            TX_STOP: begin
               if (tx_cnt_q == '0) begin
                  tx_state_q <= TX_IDLE;
                  tx_busy_q  <= 1'b0;
               end else begin
                  tx_cnt_q <= tx_cnt_q - CNT_ONE;
               end
            end
            default: begin
               tx_state_q <= TX_IDLE;
               tx_line_q  <= 1'b1;
               tx_busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign uart_txd   = tx_line_q;
   assign uart0_busy = tx_busy_q;

   logic [1:0] rx_sync_q;
   logic       rx_s;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_sync_q <= 2'b11;
      end else begin
         rx_sync_q <= {rx_sync_q[0], uart_rxd};
      end
   end

   assign rx_s = rx_sync_q[1];

   rx_state_e        rx_state_q;
   logic [CNT_W-1:0] rx_cnt_q;
   logic [2:0]       rx_idx_q;
   logic [7:0]       rx_shift_q;
   logic             rx_commit;

   // Receive FSM: half-bit wait to the start centre, then one full bit period per sample.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         case (rx_state_q)
            RX_IDLE: begin
               if (!rx_s) begin
                  rx_state_q <= RX_START;
                  rx_cnt_q   <= BIT_HALF;
               end
            end
            RX_START: begin
               if (rx_cnt_q == '0) begin
                  if (!rx_s) begin
                     rx_state_q <= RX_DATA;
                     rx_cnt_q   <= BIT_LAST;
                     rx_idx_q   <= '0;
                  end else begin
                     rx_state_q <= RX_IDLE;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q - CNT_ONE;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == '0) begin
                  rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                  rx_cnt_q   <= BIT_LAST;
                  if (rx_idx_q == 3'd7) begin
                     rx_state_q <= RX_STOP;
                  end else begin
                     rx_idx_q <= rx_idx_q + 3'd1;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q - CNT_ONE;
               end
            end
            RX_STOP: begin
               if (rx_cnt_q == '0) begin
                  rx_state_q <= RX_IDLE;
               end else begin
                  rx_cnt_q <= rx_cnt_q - CNT_ONE;
               end
            end
            default: begin
               rx_state_q <= RX_IDLE;
            end
         endcase
      end
   end

   // A byte is committed on the stop-centre cycle only when the stop bit reads high.
   assign rx_commit = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && rx_s;

`ifdef UART_RX_FIFO_EN
   logic [7:0] fifo_q [4];
   logic [1:0] rd_ptr_q;
   logic [1:0] wr_ptr_q;
   logic [2:0] count_q;
   logic [2:0] count_d;
   logic       pop;
   logic       push;

   assign pop  = uart0_rd && (count_q != 3'd0);
   // A full FIFO still accepts a byte when the same cycle frees a slot.
   assign push = rx_commit && ((count_q != 3'd4) || pop);

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 3'd1;
      end else if (pop && !push) begin
         count_d = count_q - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         for (int i = 0; i < 4; i++) begin
            fifo_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= rx_shift_q;
            wr_ptr_q         <= wr_ptr_q + 2'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 2'd1;
         end
         count_q <= count_d;
      end
   end

   assign uart0_valid = (count_q != 3'd0);
   assign uart0_data  = fifo_q[rd_ptr_q];
`else
   logic [7:0] hold_q;
   logic [7:0] hold_d;
   logic       hold_vld_q;
   logic       hold_vld_d;

   // A commit wins over a pop in the same cycle, and overwrites an unread byte.
   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (uart0_rd) begin
         hold_vld_d = 1'b0;
      end
      if (rx_commit) begin
         hold_d     = rx_shift_q;
         hold_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end

   assign uart0_valid = hold_vld_q;
   assign uart0_data  = hold_q;
`endif

endmodule
